fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode; decode drives the immediate generator.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel with a fixed-order response channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects from execute (branch/jump target): discards in-flight responses and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- BUF_DEPTH, 2, instruction buffer entries; also caps outstanding requests plus buffered entries (credit limit), range 1..8.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid (one per accepted request, in order, no backpressure).
- imem_rsp_data  in  32  returned instruction.
- dec_valid  out  1  buffer head valid.
- dec_ready  in  1  decode consumes head.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  head PC.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  32  redirect target.
- halt  in  1  stop issuing new requests.
- idle  out  1  halted with zero outstanding requests.

Behaviour:
- Reset (async, rst_n low): state=BOOT, pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, buffer empty. Outputs: imem_req_valid=0, dec_valid=0, idle=0, imem_req_addr=RESET_PC, dec_instr=0, dec_pc=0.
- FSM states: BOOT, RUN, HALTED.
  - BOOT→RUN after one clock; no request is issued in BOOT.
  - RUN→HALTED when halt=1 and outstanding=0 and no request is accepted that cycle.
  - HALTED→RUN when halt=0.
  - redirect_valid is honoured in every state except BOOT, where it is ignored.
- Issue: imem_req_valid=1 in RUN when halt=0, redirect_valid=0, and outstanding+occupancy<BUF_DEPTH. imem_req_addr=pc.
  - On handshake: pc+=4 with 32-bit wraparound, and outstanding increments.
- Response: each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: drop_cnt decrements and the data is discarded.
  - Otherwise: push {rsp_pc, data} into the buffer and rsp_pc+=4.
  - Space is guaranteed by the credit limit; overflow is a verification assertion.
- Output: dec_valid=buffer non-empty; dec_instr/dec_pc show the head. Pop on dec_valid&&dec_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - Empty buffer: a response arriving this cycle appears on dec_valid the next cycle; no combinational bypass.
- Redirect (cycle of redirect_valid):
  - Buffer flushed; any pop that cycle is discarded.
  - pc=rsp_pc=redirect_pc; imem_req_valid=0 that cycle.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0). A response in that cycle is dropped regardless of the old drop_cnt.
  - Fetch resumes next cycle at redirect_pc.
- redirect_pc[1:0] is forced to 0 when loaded, unless the optional feature is enabled.
- idle=1 exactly when state=HALTED.
- Fetch latency: request accepted at cycle N with a response at cycle N+k gives dec_valid at N+k+1.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Extra output port fetch_misalign (1 bit). It is registered, pulses high for one cycle on a redirect whose redirect_pc[1:0]≠0, and resets to 0.
  - The faulting redirect flushes as normal, then forces HALTED until a subsequent redirect arrives with halt=0.
- Undefined: no port; low bits are silently cleared.

Decomposition:
- Shared package holds: INSTR_W=32, XLEN=32, the fetch FSM state typedef, and NOP_INSTR=32'h0000_0013 (used by decode on bubbles).
- One natural sub-module: fetch_buf, a parameterised synchronous FIFO carrying {pc, instr} with flush, push, pop, count and full/empty outputs.

Test Plan:
- Reset with RESET_PC=32'h100, memory ready with 1-cycle latency, dec_ready=1 → first request at addr 32'h100 one cycle after BOOT; dec_pc sequence 100,104,108 with matching data, one instruction per cycle sustained.
- dec_ready=0 for 10 cycles, BUF_DEPTH=2 → at most 2 requests outstanding+buffered, no lost or duplicate PCs; release gives in-order 100,104.
- Redirect to 32'h200 while 2 requests are outstanding (3-cycle latency) → both stale responses are dropped; next dec_pc=200; buffer flushed in the redirect cycle.
- Redirect in the same cycle as a response and a decode pop → response discarded, pop ignored, next dec_pc=redirect target.
- halt=1 with 2 outstanding → no new requests, both responses delivered, then idle=1; halt=0 resumes at the next sequential PC.
- Assert rst_n low mid-stream → all outputs return to reset values immediately (asynchronously); fetch restarts at RESET_PC. With FETCH_ALIGN_CHECK_EN: redirect to 32'h202 → fetch_misalign high for one cycle, then HALTED until a further redirect.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Instruction and address widths, the fetch FSM state type and the buffered entry layout.
package fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // Decode inserts this instruction (addi x0, x0, 0) on bubbles.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO carrying {pc, instr} fetch entries with flush.
// Push and pop may coincide at any occupancy, including full.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = $bits(fetch_entry_t),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [W-1:0]     i_push_data,
  input  logic             i_pop,
  output logic [W-1:0]     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: storage has no reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers responses for decode, handles redirects. Optional FETCH_ALIGN_CHECK_EN adds fetch_misalign.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [INSTR_W-1:0]  dec_instr,
  output logic [XLEN-1:0]     dec_pc,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                halt,
  output logic                idle
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                fetch_misalign
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_buf_count;
  logic             w_buf_full;
  logic             w_buf_empty;
  fetch_entry_t     w_buf_head;
  fetch_entry_t     w_push_entry;
  logic             w_redirect;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             w_credit_ok;
  logic             w_req_fire;
  logic             w_rsp_keep;
  logic             w_pop;

  assign w_redirect = redirect_valid && (r_state != ST_BOOT);

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;
  logic r_misalign_hold;
  logic w_misalign;

  assign w_redirect_pc  = redirect_pc;
  assign w_misalign     = w_redirect && (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = r_misalign;

  // A misaligned redirect parks the unit in HALTED until a clean redirect arrives with halt low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign      <= 1'b0;
      r_misalign_hold <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
      if (w_misalign)                r_misalign_hold <= 1'b1;
      else if (w_redirect && !halt)  r_misalign_hold <= 1'b0;
    end
  end
`else
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Outstanding requests plus buffered entries never exceed the buffer depth.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < (CNT_W + 1)'(BUF_DEPTH);

  assign imem_req_valid = (r_state == ST_RUN) && !halt && !redirect_valid && w_credit_ok;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_rsp_keep     = imem_rsp_valid && (r_drop_cnt == '0) && !w_redirect;
  assign w_pop          = !w_buf_empty && dec_ready && !w_redirect;
  assign w_push_entry   = '{pc: r_rsp_pc, instr: imem_rsp_data};

  // NOTE: the next-state value is assigned a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT:   w_state_nxt = ST_RUN;
      ST_RUN:    if (halt && (r_outstanding == '0) && !w_req_fire) w_state_nxt = ST_HALTED;
      ST_HALTED: if (!halt) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_BOOT;
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    if (w_misalign)           w_state_nxt = ST_HALTED;
    else if (r_misalign_hold) w_state_nxt = (w_redirect && !halt) ? ST_RUN : ST_HALTED;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);
      if (w_redirect) begin
        r_pc       <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        // Everything still in flight belongs to the old stream; this cycle's response is dropped here.
        r_drop_cnt <= r_outstanding - CNT_W'(imem_rsp_valid);
      end else begin
        if (w_req_fire) r_pc     <= r_pc + 32'd4;
        if (w_rsp_keep) r_rsp_pc <= r_rsp_pc + 32'd4;
        if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (w_redirect),
    .i_push      (w_rsp_keep),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_buf_head),
    .o_count     (w_buf_count),
    .o_full      (w_buf_full),
    .o_empty     (w_buf_empty)
  );

  assign dec_valid = !w_buf_empty;
  assign dec_instr = w_buf_empty ? '0 : w_buf_head.instr;
  assign dec_pc    = w_buf_empty ? '0 : w_buf_head.pc;
  assign idle      = (r_state == ST_HALTED);

  a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rsp_keep && w_buf_full && !w_pop));

endmodule
